// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - multi-cycle execute unit: add/sub/move/swap, shift-add multiply, restoring divide
// Optional divider is compiled in with `define ALU_EXEC_DIV_EN.
module alu_exec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal
);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOV  = 4'b0101;
    localparam logic [3:0] OP_SWP  = 4'b0110;
    localparam logic [3:0] OP_AADD = 4'b0111;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

`ifdef ALU_EXEC_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // hi/lo hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic [WIDTH:0]   msum;
`ifdef ALU_EXEC_DIV_EN
    logic [WIDTH:0]   rsh;
    logic [WIDTH-1:0] rdiff;
`endif

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign msum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};
`ifdef ALU_EXEC_DIV_EN
    assign rsh    = {hi_q, lo_q[WIDTH-1]};
    assign rdiff  = rsh[WIDTH-1:0] - b_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_MUL: begin
                cnt_d        = cnt_q + 1'b1;
                {hi_d, lo_d} = {msum, lo_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
`ifdef ALU_EXEC_DIV_EN
            S_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (rsh >= {1'b0, b_q}) begin
                    hi_d = rdiff;
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = rsh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            op_d    = operation;
            a_d     = a;
            b_d     = b;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = (operation == OP_MUL) ? b : a;
            state_d = S_DONE;
            if (operation == OP_MUL) state_d = S_MUL;
`ifdef ALU_EXEC_DIV_EN
            if ((operation == OP_DIV) && (b != '0)) state_d = S_DIV;
`endif
        end
    end

    // Results are registered on the edge that leaves DONE, so done trails the DONE state by one cycle.
    always_comb begin
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        dbz_d       = 1'b0;
        ill_d       = 1'b0;
        if (state_q == S_DONE) begin
            done_d = 1'b1;
            case (op_q)
                OP_ADD, OP_AADD: begin
                    result_d    = a_q + b_q;
                    result_hi_d = '0;
                end
                OP_SUB: begin
                    result_d    = a_q - b_q;
                    result_hi_d = '0;
                end
                OP_MUL: begin
                    result_d    = lo_q;
                    result_hi_d = hi_q;
                end
`ifdef ALU_EXEC_DIV_EN
                OP_DIV: begin
                    if (b_q == '0) begin
                        result_d    = '1;
                        result_hi_d = a_q;
                        dbz_d       = 1'b1;
                    end else begin
                        result_d    = lo_q;
                        result_hi_d = hi_q;
                    end
                end
`endif
                OP_MOV: begin
                    result_d    = a_q;
                    result_hi_d = '0;
                end
                OP_SWP: begin
                    result_d    = b_q;
                    result_hi_d = a_q;
                end
                OP_NOP: ;
                default: ill_d = 1'b1;
            endcase
            if ((op_q != OP_NOP) && !ill_d) zero_d = (result_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
        end
    end

`ifdef ALU_EXEC_DIV_EN
    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign busy = (state_q == S_MUL);
`endif
    assign done        = done_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign illegal     = ill_q;

endmodule
